// File: rtl/arb_mux_reg.sv
// Purpose: N-input arbitrating mux (round-robin or fixed priority) with a registered output stage.
// Latency: one cycle from grant (in_ready high at edge k) to out_valid/out_data after edge k.
// Backpressure: out_valid && !out_ready holds the output word and forces every in_ready bit low.
module arb_mux_reg #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_INPUTS),
  parameter int RR_MODE    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_INPUTS*BUS_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]           in_valid,
  output logic [NUM_INPUTS-1:0]           in_ready,
  output logic [BUS_WIDTH-1:0]            out_data,
  output logic [SEL_WIDTH-1:0]            out_sel,
  output logic                            out_valid,
  input  logic                            out_ready
);

  // Output stage occupancy; the state bit doubles as out_valid.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_INPUTS - 1);

  state_t                 state_q, state_d;
  logic [BUS_WIDTH-1:0]   data_q, data_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic [SEL_WIDTH-1:0]   ptr_q, ptr_d;

  // Arbitration results
  logic                   lo_any;     // some channel is valid
  logic [SEL_WIDTH-1:0]   lo_idx;     // lowest valid index overall
  logic                   hi_any;     // some channel at or above ptr is valid
  logic [SEL_WIDTH-1:0]   hi_idx;     // lowest valid index at or above ptr
  logic                   grant_any;
  logic [SEL_WIDTH-1:0]   grant_idx;
  logic [BUS_WIDTH-1:0]   win_data;
  logic                   load_en;

  // Two-pass priority search: the first valid channel at or above ptr wins,
  // otherwise the search wraps to the lowest valid channel. Comparing against
  // ptr (rather than rotating by it) keeps non-power-of-two counts correct.
  always_comb begin
    lo_any = 1'b0;
    lo_idx = '0;
    hi_any = 1'b0;
    hi_idx = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (in_valid[i]) begin
        if (!lo_any) begin
          lo_any = 1'b1;
          lo_idx = SEL_WIDTH'(i);
        end
        if (!hi_any && (i >= int'(ptr_q))) begin
          hi_any = 1'b1;
          hi_idx = SEL_WIDTH'(i);
        end
      end
    end
  end

  // Pick the winner per arbitration mode; fixed priority ignores ptr.
  always_comb begin
    grant_any = lo_any;
    grant_idx = lo_idx;
    if ((RR_MODE != 0) && hi_any) begin
      grant_idx = hi_idx;
    end
  end

  // Route the winning channel's word to the output register input.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_idx == SEL_WIDTH'(i)) begin
        win_data = in_data[i*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  // State register: output word, its source index, and the round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state: load on any grant when the register is free or draining,
  // empty when draining with nothing to load, otherwise hold.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      EMPTY: begin
        if (grant_any) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d = grant_any ? FULL : EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (load_en && grant_any) begin
      data_d = win_data;
      sel_d  = grant_idx;
      if (RR_MODE != 0) begin
        ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + SEL_WIDTH'(1);
      end
    end
  end

  // Outputs: one-hot grant only when the register can take a word and reset is released.
  always_comb begin
    load_en   = (state_q == EMPTY) || out_ready;
    out_valid = (state_q == FULL);
    out_data  = data_q;
    out_sel   = sel_q;
    in_ready  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!rst && load_en && grant_any && (grant_idx == SEL_WIDTH'(i))) begin
        in_ready[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_reg.sv
// Directed bench for arb_mux_reg: three instances cover round-robin N=4,
// fixed priority N=4 and round-robin N=3 (non-power-of-two wrap).
module tb_arb_mux_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Instance A: N=4, round-robin
  logic [31:0] a_data  = '0;
  logic [3:0]  a_valid = '0;
  logic [3:0]  a_rdy;
  logic [7:0]  a_odata;
  logic [1:0]  a_osel;
  logic        a_ovld;
  logic        a_ordy  = 1'b0;

  // Instance B: N=4, fixed priority
  logic [31:0] b_data  = '0;
  logic [3:0]  b_valid = '0;
  logic [3:0]  b_rdy;
  logic [7:0]  b_odata;
  logic [1:0]  b_osel;
  logic        b_ovld;
  logic        b_ordy  = 1'b0;

  // Instance C: N=3, round-robin
  logic [23:0] c_data  = '0;
  logic [2:0]  c_valid = '0;
  logic [2:0]  c_rdy;
  logic [7:0]  c_odata;
  logic [1:0]  c_osel;
  logic        c_ovld;
  logic        c_ordy  = 1'b0;

  arb_mux_reg #(.BUS_WIDTH(8), .NUM_INPUTS(4), .RR_MODE(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_rdy),
    .out_data(a_odata), .out_sel(a_osel), .out_valid(a_ovld), .out_ready(a_ordy)
  );

  arb_mux_reg #(.BUS_WIDTH(8), .NUM_INPUTS(4), .RR_MODE(0)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_rdy),
    .out_data(b_odata), .out_sel(b_osel), .out_valid(b_ovld), .out_ready(b_ordy)
  );

  arb_mux_reg #(.BUS_WIDTH(8), .NUM_INPUTS(3), .RR_MODE(1)) dut_c (
    .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_rdy),
    .out_data(c_odata), .out_sel(c_osel), .out_valid(c_ovld), .out_ready(c_ordy)
  );

  task automatic test_reset();
    a_valid = 4'b1111;
    a_ordy  = 1'b1;
    @(negedge clk);
    total_cnt++; if (a_rdy !== 4'b0000) $display("FAIL rst_in_ready: got %b want 0000", a_rdy); else pass_cnt++;
    total_cnt++; if (a_ovld !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", a_ovld); else pass_cnt++;
    total_cnt++; if (a_odata !== 8'h00) $display("FAIL rst_out_data: got %h want 00", a_odata); else pass_cnt++;
    // Load 0xA5 and stall it, then reset mid-transfer.
    @(posedge clk); #1;
    rst     = 1'b0;
    a_valid = 4'b0001;
    a_data  = {8'h00, 8'h00, 8'h00, 8'hA5};
    a_ordy  = 1'b0;
    #1;
    total_cnt++; if (a_rdy !== 4'b0001) $display("FAIL rst_load_grant: got %b want 0001", a_rdy); else pass_cnt++;
    @(posedge clk); #1;
    a_valid = 4'b0000;
    total_cnt++; if (a_ovld !== 1'b1 || a_odata !== 8'hA5) $display("FAIL rst_preload: got v=%b d=%h want v=1 d=a5", a_ovld, a_odata); else pass_cnt++;
    a_valid = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++; if (a_ovld !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", a_ovld); else pass_cnt++;
    total_cnt++; if (a_odata !== 8'h00) $display("FAIL rst_async_data: got %h want 00", a_odata); else pass_cnt++;
    total_cnt++; if (a_osel !== 2'd0) $display("FAIL rst_async_sel: got %0d want 0", a_osel); else pass_cnt++;
    total_cnt++; if (a_rdy !== 4'b0000) $display("FAIL rst_async_in_ready: got %b want 0000", a_rdy); else pass_cnt++;
    @(posedge clk); #1;
    rst     = 1'b0;
    a_valid = 4'b0000;
  endtask

  task automatic test_rr_sweep();
    logic [1:0] exp_sel;
    a_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    a_valid = 4'b1111;
    a_ordy  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      exp_sel = 2'(k % 4);
      total_cnt++; if (a_osel !== exp_sel) $display("FAIL rr_sweep_sel[%0d]: got %0d want %0d", k, a_osel, exp_sel); else pass_cnt++;
      total_cnt++; if (a_ovld !== 1'b1 || a_odata !== 8'h10 + 8'(k % 4))
        $display("FAIL rr_sweep_word[%0d]: got v=%b d=%h want v=1 d=%h", k, a_ovld, a_odata, 8'h10 + 8'(k % 4)); else pass_cnt++;
    end
    a_valid = 4'b0000;
    @(posedge clk); #1;
    total_cnt++; if (a_ovld !== 1'b0) $display("FAIL rr_sweep_drain: got %b want 0", a_ovld); else pass_cnt++;
  endtask

  task automatic test_single();
    a_data  = {8'h00, 8'h3C, 8'h00, 8'h00};
    a_valid = 4'b0100;
    a_ordy  = 1'b1;
    #1;
    total_cnt++; if (a_rdy !== 4'b0100) $display("FAIL single_in_ready: got %b want 0100", a_rdy); else pass_cnt++;
    @(posedge clk); #1;
    a_valid = 4'b0000;
    total_cnt++; if (a_odata !== 8'h3C) $display("FAIL single_data: got %h want 3c", a_odata); else pass_cnt++;
    total_cnt++; if (a_osel !== 2'd2) $display("FAIL single_sel: got %0d want 2", a_osel); else pass_cnt++;
    total_cnt++; if (a_ovld !== 1'b1) $display("FAIL single_valid: got %b want 1", a_ovld); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    // ptr is 3 after granting channel 2; wrap search picks channel 0, ptr -> 1.
    a_data  = {8'h00, 8'h00, 8'h00, 8'h11};
    a_valid = 4'b0001;
    a_ordy  = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (a_odata !== 8'h11 || dut_a.ptr_q !== 2'd1)
      $display("FAIL bp_setup: got d=%h ptr=%0d want d=11 ptr=1", a_odata, dut_a.ptr_q); else pass_cnt++;
    a_data  = {8'h00, 8'h00, 8'h31, 8'h30};
    a_valid = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      #1;
      total_cnt++; if (a_rdy !== 4'b0000) $display("FAIL bp_in_ready[%0d]: got %b want 0000", k, a_rdy); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (a_odata !== 8'h11 || a_ovld !== 1'b1 || dut_a.ptr_q !== 2'd1)
        $display("FAIL bp_hold[%0d]: got d=%h v=%b ptr=%0d want d=11 v=1 ptr=1", k, a_odata, a_ovld, dut_a.ptr_q); else pass_cnt++;
    end
    a_ordy = 1'b1;
    #1;
    total_cnt++; if (a_rdy !== 4'b0010) $display("FAIL bp_release_grant: got %b want 0010", a_rdy); else pass_cnt++;
    @(posedge clk); #1;
    a_valid = 4'b0000;
    total_cnt++; if (a_osel !== 2'd1 || a_odata !== 8'h31)
      $display("FAIL bp_release_word: got sel=%0d d=%h want sel=1 d=31", a_osel, a_odata); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_fixed_priority();
    b_data  = {8'h23, 8'h00, 8'h21, 8'h00};
    b_valid = 4'b1010;
    b_ordy  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total_cnt++; if (b_rdy !== 4'b0010) $display("FAIL fp_in_ready[%0d]: got %b want 0010", k, b_rdy); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (b_osel !== 2'd1 || b_odata !== 8'h21 || b_ovld !== 1'b1)
        $display("FAIL fp_word[%0d]: got sel=%0d d=%h v=%b want sel=1 d=21 v=1", k, b_osel, b_odata, b_ovld); else pass_cnt++;
    end
    b_valid = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap_empty();
    c_data  = {8'h5A, 8'h00, 8'h00};
    c_valid = 3'b100;
    c_ordy  = 1'b1;
    @(posedge clk); #1;
    c_valid = 3'b000;
    total_cnt++; if (c_osel !== 2'd2 || c_odata !== 8'h5A || c_ovld !== 1'b1)
      $display("FAIL wrap_grant: got sel=%0d d=%h v=%b want sel=2 d=5a v=1", c_osel, c_odata, c_ovld); else pass_cnt++;
    total_cnt++; if (dut_c.ptr_q !== 2'd0) $display("FAIL wrap_ptr: got %0d want 0", dut_c.ptr_q); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (c_ovld !== 1'b0) $display("FAIL wrap_empty_valid: got %b want 0", c_ovld); else pass_cnt++;
    total_cnt++; if (c_odata !== 8'h5A || c_osel !== 2'd2)
      $display("FAIL wrap_empty_hold: got d=%h sel=%0d want d=5a sel=2", c_odata, c_osel); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_sel;
    logic [1:0] exp_ptr;
    // Empty stage grants regardless of out_ready.
    c_data  = {8'h62, 8'h61, 8'h60};
    c_valid = 3'b001;
    c_ordy  = 1'b0;
    #1;
    total_cnt++; if (c_rdy !== 3'b001) $display("FAIL b2b_empty_grant: got %b want 001", c_rdy); else pass_cnt++;
    c_valid = 3'b111;
    c_ordy  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      exp_sel = 2'(k % 3);
      exp_ptr = 2'((k + 1) % 3);
      total_cnt++; if (c_osel !== exp_sel || c_odata !== 8'h60 + 8'(k % 3) || c_ovld !== 1'b1)
        $display("FAIL b2b_word[%0d]: got sel=%0d d=%h v=%b want sel=%0d d=%h v=1", k, c_osel, c_odata, c_ovld, exp_sel, 8'h60 + 8'(k % 3)); else pass_cnt++;
      total_cnt++; if (dut_c.ptr_q !== exp_ptr) $display("FAIL b2b_ptr[%0d]: got %0d want %0d", k, dut_c.ptr_q, exp_ptr); else pass_cnt++;
    end
    c_valid = 3'b000;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_rr_sweep();
    test_single();
    test_backpressure();
    test_fixed_priority();
    test_wrap_empty();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
